// File: rtl/frame_color_classifier.sv
// frame_color_classifier: scans an RGB332 frame buffer and reports its dominant colour.
// Pixels are counted per strictly dominant channel; the largest qualifying count wins.
module frame_color_classifier #(
   parameter int AW      = 15,
   parameter int DW      = 8,
   parameter int NUM_PX  = 19200,
   parameter int MIN_LVL = 3,
   parameter int MIN_PX  = 1920
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          init,
   input  logic [DW-1:0] data,
   output logic [AW-1:0] addr,
   output logic          busy,
   output logic          done,
   output logic [2:0]    res
);
   typedef enum logic [2:0] {IDLE, READ, DRAIN, DECIDE, DONE} state_t;
   localparam logic [AW-1:0] LAST = AW'(NUM_PX - 1);
   localparam logic [AW-1:0] MINP = AW'(MIN_PX);
   localparam logic [2:0]    LVL  = 3'(MIN_LVL);
   state_t          r_state, w_next;
   logic            r_vld;
   logic [AW-1:0]   r_cr, r_cg, r_cb, w_win;
   logic [2:0]      w_r, w_g, w_b, w_pick, w_res;
   logic            w_red, w_grn, w_blu;
   assign w_r   = data[7:5];
   assign w_g   = data[4:2];
   assign w_b   = {data[1:0], data[1]};
   assign w_red = (w_r > w_g) && (w_r > w_b) && (w_r >= LVL);
   assign w_grn = (w_g > w_r) && (w_g > w_b) && (w_g >= LVL);
   assign w_blu = (w_b > w_r) && (w_b > w_g) && (w_b >= LVL);
   // Ties between counts resolve red > green > blue.
   assign w_pick = (r_cr >= r_cg && r_cr >= r_cb) ? 3'b100 : (r_cg >= r_cb) ? 3'b010 : 3'b001;
   assign w_win  = w_pick[2] ? r_cr : w_pick[1] ? r_cg : r_cb;
   assign w_res  = (w_win < MINP) ? 3'b000 : w_pick;
   always_comb begin
      w_next = r_state;
      busy   = 1'b0;
      done   = 1'b0;
      unique case (r_state)
         IDLE:   w_next = init ? READ : IDLE;
         READ:   begin
            busy   = 1'b1;
            w_next = (addr == LAST) ? DRAIN : READ;
         end
         DRAIN:  begin
            busy   = 1'b1;
            w_next = DECIDE;
         end
         DECIDE: begin
            busy   = 1'b1;
            w_next = DONE;
         end
         DONE:   begin
            done   = 1'b1;
            w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
         addr    <= '0;
         r_vld   <= 1'b0;
         r_cr    <= '0;
         r_cg    <= '0;
         r_cb    <= '0;
         res     <= 3'b000;
      end else begin
         r_state <= w_next;
         r_vld   <= (r_state == READ);
         // Pixel data lags its address by one cycle, hence the valid delay.
         if (r_state == IDLE && init) begin
            addr <= '0;
            r_cr <= '0;
            r_cg <= '0;
            r_cb <= '0;
         end else begin
            if (r_state == READ && addr != LAST) addr <= addr + 1'b1;
            if (r_vld) begin
               r_cr <= r_cr + AW'(w_red);
               r_cg <= r_cg + AW'(w_grn);
               r_cb <= r_cb + AW'(w_blu);
            end
         end
         if (r_state == DECIDE) res <= w_res;
      end
   end
endmodule

// File: tb/tb_frame_color_classifier.sv
// tb_frame_color_classifier: directed frames with a scoreboard of expected results.
module tb_frame_color_classifier;
   localparam int AW = 15;
   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          init = 1'b0;
   logic [7:0]    data;
   logic [AW-1:0] addr;
   logic          busy, done;
   logic [2:0]    res;
   logic [7:0]    mem [16];
   typedef struct {logic [2:0] r; int c;} exp_t;
   exp_t sb[$];
   int ncyc = 0, checks = 0, errs = 0;

   frame_color_classifier #(.AW(AW), .DW(8), .NUM_PX(16), .MIN_LVL(3), .MIN_PX(4)) dut (
      .clk(clk), .rst(rst), .init(init), .data(data),
      .addr(addr), .busy(busy), .done(done), .res(res));

   always #5 clk = ~clk;
   always @(posedge clk) data <= mem[addr[3:0]];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      ncyc++;
      if (done === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            errs++;
            $display("FAIL unexpected_done: got done=1 expected no pending frame (t=%0t)", $time);
         end else begin
            e = sb.pop_front();
            chk("res", res, e.r);
            chk("done_cycle", ncyc, e.c);
            chk("busy_in_done", busy, 0);
         end
      end
   end

   task automatic fill(input logic [7:0] a, input int na, input logic [7:0] b, input int nb, input logic [7:0] c);
      for (int i = 0; i < 16; i++) mem[i] = (i < na) ? a : (i < na + nb) ? b : c;
   endtask

   task automatic start(input bit push, input logic [2:0] e);
      @(negedge clk);
      init = 1'b1;
      @(posedge clk);
      if (push) sb.push_back('{r: e, c: ncyc + 19});
      #1 init = 1'b0;
   endtask

   task automatic scan(input logic [2:0] hold, input int reinit_k);
      int n = 0;
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         chk("addr", addr, k);
         chk("busy", busy, 1);
         chk("res_hold", res, hold);
         init = (k == reinit_k);
      end
      init = 1'b0;
      while (done !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("done_seen", done, 1);
      @(negedge clk);
      chk("busy_after", busy, 0);
      chk("done_after", done, 0);
      chk("addr_held", addr, 15);
   endtask

   task automatic frame(input logic [2:0] hold, input logic [2:0] e, input int reinit_k);
      start(1'b1, e);
      scan(hold, reinit_k);
   endtask

   initial begin
      fill(8'h00, 16, 8'h00, 0, 8'h00);
      repeat (2) @(negedge clk);
      chk("rst_addr", addr, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_res", res, 0);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      fill(8'hE0, 16, 8'h00, 0, 8'h00);
      frame(3'b000, 3'b100, -1);
      fill(8'h1C, 6, 8'h03, 6, 8'h00);
      frame(3'b100, 3'b010, -1);
      fill(8'h49, 16, 8'h00, 0, 8'h00);
      frame(3'b010, 3'b000, -1);
      fill(8'h24, 16, 8'h00, 0, 8'h00);
      frame(3'b000, 3'b000, -1);
      fill(8'h03, 3, 8'h00, 13, 8'h00);
      frame(3'b000, 3'b000, -1);
      fill(8'h03, 4, 8'h00, 12, 8'h00);
      frame(3'b000, 3'b001, -1);
      fill(8'hE0, 5, 8'h1C, 5, 8'h00);
      frame(3'b001, 3'b100, -1);
      fill(8'h1C, 16, 8'h00, 0, 8'h00);
      frame(3'b100, 3'b010, 5);
      fill(8'hE0, 16, 8'h00, 0, 8'h00);
      frame(3'b010, 3'b100, -1);
      start(1'b0, 3'b000);
      for (int n = 0; n < 30 && addr != 8; n++) @(negedge clk);
      chk("abort_addr8", addr, 8);
      rst = 1'b0;
      #1;
      chk("abort_addr", addr, 0);
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_res", res, 0);
      repeat (25) @(negedge clk);
      chk("abort_idle_done", done, 0);
      rst = 1'b1;
      @(negedge clk);
      fill(8'h03, 10, 8'h00, 6, 8'h00);
      frame(3'b000, 3'b001, -1);
      fill(8'hE0, 16, 8'h00, 0, 8'h00);
      frame(3'b001, 3'b100, -1);
      fill(8'h03, 16, 8'h00, 0, 8'h00);
      frame(3'b100, 3'b001, -1);
      repeat (3) @(negedge clk);
      chk("sb_empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
